// File: rtl/nn_loop_counter.sv
// Two-level nested loop counter producing (outer, inner) index pairs for layer
// addressing, with start/done handshake, stall via en, and saturate or wrap end behaviour.
module nn_loop_counter #(
  parameter int CNT_W = 16,
  parameter bit WRAP  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               en,
  input  logic [CNT_W-1:0]   inner_end,
  input  logic [CNT_W-1:0]   outer_end,
  output logic [CNT_W-1:0]   inner_idx,
  output logic [CNT_W-1:0]   outer_idx,
  output logic               busy,
  output logic               row_done,
  output logic               done,
  output logic               done_pulse,
  output logic [2*CNT_W-1:0] step_cnt
);

  localparam int STEP_W = 2 * CNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    inner_q, inner_d;
  logic [CNT_W-1:0]    outer_q, outer_d;
  logic [CNT_W-1:0]    inner_end_q, inner_end_d;
  logic [CNT_W-1:0]    outer_end_q, outer_end_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                row_q, row_d;
  logic                dp_q, dp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      inner_q     <= '0;
      outer_q     <= '0;
      inner_end_q <= '0;
      outer_end_q <= '0;
      step_q      <= '0;
      row_q       <= 1'b0;
      dp_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      inner_q     <= inner_d;
      outer_q     <= outer_d;
      inner_end_q <= inner_end_d;
      outer_end_q <= outer_end_d;
      step_q      <= step_d;
      row_q       <= row_d;
      dp_q        <= dp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inner_d     = inner_q;
    outer_d     = outer_q;
    inner_end_d = inner_end_q;
    outer_end_d = outer_end_q;
    step_d      = step_q;
    row_d       = 1'b0;
    dp_d        = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          inner_end_d = inner_end;
          outer_end_d = outer_end;
          inner_d     = '0;
          outer_d     = '0;
          step_d      = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (en) begin
          step_d = step_q + STEP_W'(1);
          if (inner_q != inner_end_q) begin
            inner_d = inner_q + CNT_W'(1);
          end else begin
            row_d = 1'b1;
            if (outer_q != outer_end_q) begin
              inner_d = '0;
              outer_d = outer_q + CNT_W'(1);
            end else begin
              // Final step of the pass: either restart or park on terminal indices.
              dp_d = 1'b1;
              if (WRAP) begin
                inner_d = '0;
                outer_d = '0;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inner_idx  = inner_q;
  assign outer_idx  = outer_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign row_done   = row_q;
  assign done_pulse = dp_q;
  assign step_cnt   = step_q;

endmodule

// File: tb/tb_nn_loop_counter.sv
// Scoreboard bench for nn_loop_counter: a WRAP=0 and a WRAP=1 instance share stimulus and
// are checked against a linear-position reference model (index = position div/mod row length).
module tb_nn_loop_counter;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, en;
  logic [W-1:0] inner_end, outer_end;

  logic [W-1:0]   ii [2];
  logic [W-1:0]   oi [2];
  logic           busy [2];
  logic           rowd [2];
  logic           done [2];
  logic           dpul [2];
  logic [2*W-1:0] step [2];

  nn_loop_counter #(.CNT_W(W), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .inner_end(inner_end), .outer_end(outer_end),
    .inner_idx(ii[0]), .outer_idx(oi[0]), .busy(busy[0]), .row_done(rowd[0]),
    .done(done[0]), .done_pulse(dpul[0]), .step_cnt(step[0]));

  nn_loop_counter #(.CNT_W(W), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .inner_end(inner_end), .outer_end(outer_end),
    .inner_idx(ii[1]), .outer_idx(oi[1]), .busy(busy[1]), .row_done(rowd[1]),
    .done(done[1]), .done_pulse(dpul[1]), .step_cnt(step[1]));

  typedef struct {
    logic [W-1:0]   ii;
    logic [W-1:0]   oi;
    logic           busy;
    logic           row;
    logic           done;
    logic           dp;
    logic [2*W-1:0] step;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: a pass is a linear walk pos = 0..N-1 over N = (ie+1)*(oe+1) points.
  bit          m_run [2];
  bit          m_done[2];
  bit          m_row [2];
  bit          m_dp  [2];
  longint      m_pos [2];
  longint      m_ie  [2];
  longint      m_oe  [2];
  logic [2*W-1:0] m_steps[2];

  int vectors = 0;
  int miscompares = 0;

  function automatic exp_t model_out(int w);
    exp_t e;
    e.ii   = W'(m_pos[w] % (m_ie[w] + 1));
    e.oi   = W'(m_pos[w] / (m_ie[w] + 1));
    e.busy = m_run[w];
    e.row  = m_row[w];
    e.done = m_done[w];
    e.dp   = m_dp[w];
    e.step = m_steps[w];
    return e;
  endfunction

  task automatic model_edge(int w);
    longint n;
    m_row[w] = 0;
    m_dp[w]  = 0;
    if (rst) begin
      m_run[w] = 0; m_done[w] = 0; m_pos[w] = 0;
      m_ie[w] = 0; m_oe[w] = 0; m_steps[w] = '0;
    end else if (!m_run[w]) begin
      if (start) begin
        m_ie[w] = longint'(inner_end);
        m_oe[w] = longint'(outer_end);
        m_pos[w] = 0; m_steps[w] = '0; m_run[w] = 1; m_done[w] = 0;
      end
    end else if (en) begin
      n = (m_ie[w] + 1) * (m_oe[w] + 1);
      m_steps[w] = m_steps[w] + 1;
      m_pos[w] = m_pos[w] + 1;
      if (m_pos[w] % (m_ie[w] + 1) == 0) m_row[w] = 1;
      if (m_pos[w] == n) begin
        m_dp[w] = 1;
        if (w == 0) begin
          m_run[w] = 0; m_done[w] = 1; m_pos[w] = n - 1;
        end else begin
          m_pos[w] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    #1;
  endtask

  task automatic drive(bit r, bit s, bit e, int ie, int oe, int n);
    rst = r; start = s; en = e;
    inner_end = W'(ie); outer_end = W'(oe);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(string name, int w, longint act, longint exp_v);
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s[wrap=%0d] t=%0t actual=%0d expected=%0d", name, w, $time, act, exp_v);
    end
  endtask

  task automatic compare(int w, exp_t e);
    vectors++;
    chk("inner_idx",  w, longint'(ii[w]),   longint'(e.ii));
    chk("outer_idx",  w, longint'(oi[w]),   longint'(e.oi));
    chk("busy",       w, longint'(busy[w]), longint'(e.busy));
    chk("row_done",   w, longint'(rowd[w]), longint'(e.row));
    chk("done",       w, longint'(done[w]), longint'(e.done));
    chk("done_pulse", w, longint'(dpul[w]), longint'(e.dp));
    chk("step_cnt",   w, longint'(step[w]), longint'(e.step));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      compare(0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare(1, e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 1; en = 1; inner_end = '0; outer_end = '0;
    // Reset held with start/en high, then idle with no start.
    drive(1, 1, 1, 5, 5, 2);
    drive(0, 0, 1, 5, 5, 3);
    // Nominal 4x3 pass.
    drive(0, 1, 1, 3, 2, 1);
    drive(0, 0, 1, 0, 0, 14);
    // Stall mid-row plus ignored start with changed limits.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 3, 2, 1);
    drive(0, 0, 1, 3, 2, 2);
    drive(0, 0, 0, 3, 2, 3);
    drive(0, 1, 1, 7, 7, 1);
    drive(0, 0, 1, 7, 7, 12);
    // Zero limits, then a single-column pass.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 2);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 3, 1);
    drive(0, 0, 1, 0, 3, 5);
    // 2x2 wrap behaviour over 10 advances, then immediate restart from DONE.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 1, 1, 1);
    drive(0, 0, 1, 1, 1, 10);
    drive(0, 1, 1, 2, 0, 1);
    drive(0, 0, 1, 2, 0, 4);
    // Reset mid-pass at (2,1), then a clean pass.
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 3, 2, 1);
    drive(0, 0, 1, 3, 2, 6);
    drive(1, 1, 1, 3, 2, 1);
    drive(0, 1, 1, 3, 2, 1);
    drive(0, 0, 1, 3, 2, 5);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 4)),
            int'($urandom_range(0, 4)), 1);
    end
    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending=%0d expected=0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
